// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding, frame constants and the word-count legality rule.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] HDR_BYTE       = 8'hA5;
    localparam int         MAX_WORDS      = 4096;
    localparam int         BYTES_PER_WORD = 4;
    // 13 bits carries N = {CNT_HI[4:0], CNT_LO}, enough to hold MAX_WORDS itself.
    localparam int         CNT_W          = 13;

    function automatic logic cnt_legal(input logic [7:0] hi, input logic [7:0] lo);
        logic [CNT_W-1:0] n;
        n = {hi[4:0], lo};
        return (hi[7:5] == 3'd0) && (n <= CNT_W'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write / status bundle of the loader.
// slave is the loader side; master is the stream source and memory/CPU side.
interface prog_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Shifts bytes MSB-first into a word; word_vld_o pulses the cycle after the 4th byte.
// No backpressure of its own: the parent must not offer a byte while word_vld_o is high.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_dat_i,
    output logic [DATA_W-1:0] word_dat_o,
    output logic              word_vld_o
);
    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic              vld_q, vld_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        vld_d  = 1'b0;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (byte_vld_i) begin
            word_d = {word_q[DATA_W-9:0], byte_dat_i};
            idx_d  = idx_q + 2'd1;
            vld_d  = (idx_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= 2'd0;
            vld_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
        end
    end

    assign word_dat_o = word_q;
    assign word_vld_o = vld_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte stream -> instruction memory loader; one write cycle per 4 payload bytes.
// in_ready drops only during the write cycle; the CPU is held in reset until a frame verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic         clock,
    input  logic         reset,
    prog_loader_if.slave bus
);
    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              accept;
    logic              is_hdr;
    logic              pack_clr;
    logic              pack_vld;
    logic              word_vld;
    logic [DATA_W-1:0] word_dat;
    logic [CNT_W-1:0]  frame_n;

    // The write cycle is the only cycle a byte cannot be taken.
    assign bus.in_ready = reset && !word_vld;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_hdr       = (bus.in_data == HDR_BYTE);
    assign frame_n      = {cnt_hi_q[4:0], bus.in_data};

    prog_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk_i      (clock),
        .rst_ni     (reset),
        .clr_i      (pack_clr),
        .byte_vld_i (pack_vld),
        .byte_dat_i (bus.in_data),
        .word_dat_o (word_dat),
        .word_vld_o (word_vld)
    );

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        words_left_d = words_left_q;
        wr_addr_d    = wr_addr_q;
        csum_d       = csum_q;
        pack_clr     = 1'b0;
        pack_vld     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && is_hdr) state_d = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = bus.in_data;
                    state_d  = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    csum_d = 8'h00;
                    if (!cnt_legal(cnt_hi_q, bus.in_data)) begin
                        state_d = ST_ERR;
                    end else if (frame_n == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d      = ST_DATA;
                        words_left_d = frame_n;
                        wr_addr_d    = '0;
                        pack_clr     = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                // The write cycle advances the address; the last word's write ends the payload.
                if (word_vld) begin
                    wr_addr_d    = wr_addr_q + ADDR_W'(1);
                    words_left_d = words_left_q - CNT_W'(1);
                    if (words_left_q == CNT_W'(1)) state_d = ST_CSUM;
                end else if (accept) begin
                    pack_vld = 1'b1;
                    csum_d   = csum_q ^ bus.in_data;
                end
            end
            ST_CSUM: begin
                if (accept) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (accept && is_hdr) state_d = ST_CNT_HI;
            end
            default: state_d = ST_IDLE;
        endcase

        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_hi_q     <= 8'h00;
            words_left_q <= '0;
            wr_addr_q    <= '0;
            csum_q       <= 8'h00;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            words_left_q <= words_left_d;
            wr_addr_q    <= wr_addr_d;
            csum_q       <= csum_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign bus.wr_en     = word_vld;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = word_dat;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

    a_done_error_excl: assert property (@(posedge clock) disable iff (!reset)
        !(done_q && error_q));
    a_wr_not_b2b: assert property (@(posedge clock) disable iff (!reset)
        word_vld |=> !word_vld);

endmodule

// File: tb/tb_prog_loader.sv
// Drives framed byte streams and checks writes and status against a word-level model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_err = 0;
    int          gap_kind = 0;
    wr_t         wr_log[$];
    logic [31:0] frame_words[$];
    logic [7:0]  pre_bytes[$];
    logic        prev_wr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset && bus.wr_en === 1'b1) begin
            wr_log.push_back('{addr: bus.wr_addr, data: bus.wr_data});
            chk("rdy_in_wr", 64'(bus.in_ready), 64'd0);
            chk("wr_b2b", 64'(prev_wr), 64'd0);
        end
        prev_wr = (bus.wr_en === 1'b1);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    function automatic logic [7:0] rnd_nohdr();
        logic [7:0] b;
        do b = 8'($urandom); while (b == HDR_BYTE);
        return b;
    endfunction

    // Offer one byte and hold it until it transfers on a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clock);
        if (gap_kind == 1 || (gap_kind == 2 && $urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
            @(negedge clock);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            chk("rdy_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            @(posedge clock);
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends pre_bytes then a frame of frame_words; cs_flip != 0 corrupts the checksum.
    task automatic run_frame(input logic [7:0] cs_flip);
        logic [7:0]       cs;
        logic [CNT_W-1:0] n13;
        int               n;
        logic             bad;
        n   = frame_words.size();
        n13 = CNT_W'(n);
        bad = (cs_flip != 8'h00);
        cs  = 8'h00;
        foreach (frame_words[i])
            cs ^= frame_words[i][31:24] ^ frame_words[i][23:16] ^
                  frame_words[i][15:8]  ^ frame_words[i][7:0];
        wr_log.delete();
        foreach (pre_bytes[i]) send_byte(pre_bytes[i]);
        send_byte(HDR_BYTE);
        send_byte({3'b000, n13[12:8]});
        send_byte(n13[7:0]);
        foreach (frame_words[i])
            for (int k = 3; k >= 0; k--) send_byte(frame_words[i][8*k +: 8]);
        chk("cpu_rst_loading", 64'(bus.cpu_reset), 64'd1);
        chk("done_loading", 64'(bus.done), 64'd0);
        send_byte(cs ^ cs_flip);
        @(negedge clock);
        chk("done", 64'(bus.done), 64'(!bad));
        chk("error", 64'(bus.error), 64'(bad));
        chk("cpu_rst", 64'(bus.cpu_reset), 64'(bad));
        chk("n_writes", 64'(wr_log.size()), 64'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            chk("wr_addr", 64'(wr_log[i].addr), 64'(i % (1 << ADDR_W)));
            chk("wr_data", 64'(wr_log[i].data), 64'(frame_words[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"},   64'(bus.wr_en),     64'd0);
        chk({tag, "_wr_addr"}, 64'(bus.wr_addr),   64'd0);
        chk({tag, "_wr_data"}, 64'(bus.wr_data),   64'd0);
        chk({tag, "_cpu_rst"}, 64'(bus.cpu_reset), 64'd1);
        chk({tag, "_done"},    64'(bus.done),      64'd0);
        chk({tag, "_error"},   64'(bus.error),     64'd0);
        chk({tag, "_in_rdy"},  64'(bus.in_ready),  64'd0);
    endtask

    task automatic set_frame1();
        frame_words.delete();
        frame_words.push_back(32'h12345678);
        frame_words.push_back(32'h9ABCDEF0);
        pre_bytes.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b1;

        // Two-word frame; its eight payload bytes XOR to 00, so 88 is a bad checksum.
        set_frame1();
        run_frame(8'h00);
        run_frame(8'h88);

        // Leading garbage then an empty frame.
        frame_words.delete();
        pre_bytes.delete();
        pre_bytes.push_back(8'h00);
        pre_bytes.push_back(8'hFF);
        pre_bytes.push_back(8'h5A);
        run_frame(8'h00);

        // Oversized count, then discarded payload, then recovery.
        pre_bytes.delete();
        wr_log.delete();
        send_byte(HDR_BYTE);
        send_byte(8'h10);
        send_byte(8'h01);
        @(negedge clock);
        chk("n4097_error", 64'(bus.error), 64'd1);
        chk("n4097_cpu_rst", 64'(bus.cpu_reset), 64'd1);
        chk("n4097_done", 64'(bus.done), 64'd0);
        repeat (8) send_byte(rnd_nohdr());
        @(negedge clock);
        chk("err_hold", 64'(bus.error), 64'd1);
        chk("err_no_wr", 64'(wr_log.size()), 64'd0);
        frame_words.delete();
        run_frame(8'h00);

        // Nonzero CNT_HI[7:5] with an otherwise small count.
        send_byte(HDR_BYTE);
        send_byte(8'h20);
        send_byte(8'h00);
        @(negedge clock);
        chk("cnthi_error", 64'(bus.error), 64'd1);
        chk("cnthi_done", 64'(bus.done), 64'd0);

        // Reset after the 6th byte of the two-word frame.
        set_frame1();
        send_byte(HDR_BYTE);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        wr_log.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clock);
        chk("midrst_no_wr", 64'(wr_log.size()), 64'd0);
        reset = 1'b1;
        run_frame(8'h00);

        // Same frame with in_valid low every other cycle.
        gap_kind = 1;
        run_frame(8'h00);

        // Randomized frames, random gaps, garbage and occasional bad checksums.
        gap_kind = 2;
        for (int f = 0; f < 24; f++) begin
            frame_words.delete();
            pre_bytes.delete();
            for (int i = 0; i < $urandom_range(0, 6); i++) frame_words.push_back($urandom);
            for (int i = 0; i < $urandom_range(0, 2); i++) pre_bytes.push_back(rnd_nohdr());
            run_frame(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        end

        // Maximum-length frame; the 4096th write wraps the address to 0.
        gap_kind = 0;
        frame_words.delete();
        pre_bytes.delete();
        for (int i = 0; i < MAX_WORDS; i++) frame_words.push_back($urandom);
        run_frame(8'h00);
        chk("addr_wrap", 64'(bus.wr_addr), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
